top: RTL and testbench
======================

Name: top

Overview:
- Three-car elevator controller. Each car has its own 3-bit floor request input, its own soft reset, and a 3-bit current-floor output.
- Cars are independent, identical instances of one per-car FSM, all clocked by a shared clock.
- Sits between the request-decode logic and the floor-indicator/motor drivers.

Parameters:
- MOVE_CYCLES, 2, clock cycles spent travelling one floor (must be ≥1).
- DOOR_CYCLES, 2, clock cycles the door stays open on arrival (must be ≥1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  global reset; synchronous, active-high; resets all three cars.
- rst1  input  1  car 1 soft reset; synchronous, active-high.
- rst2  input  1  car 2 soft reset; synchronous, active-high.
- rst3  input  1  car 3 soft reset; synchronous, active-high.
- floor1  input  3  car 1 requested floor, 0–7; level-sampled every cycle.
- floor2  input  3  car 2 requested floor, 0–7.
- floor3  input  3  car 3 requested floor, 0–7.
- out1  output  3  car 1 current floor, registered.
- out2  output  3  car 2 current floor, registered.
- out3  output  3  car 3 current floor, registered.

Behaviour:
- Car N reset condition: rst OR rstN, sampled on the clock edge. On reset: current floor = 0, state = IDLE, step counter = 0, door counter = 0, outN = 3'b000. Reset overrides all other activity, including mid-move or mid-door; the car returns to floor 0 immediately and does not animate back down.
- outN always equals the car's current-floor register. There is no combinational path from floorN to outN.
- Per-car states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE:
  - floorN > current: next state MOVE_UP, counter = 0.
  - floorN < current: next state MOVE_DOWN, counter = 0.
  - floorN == current: stay IDLE. No door cycle is generated.
- MOVE_UP / MOVE_DOWN:
  - Counter increments each cycle.
  - When counter == MOVE_CYCLES-1: current floor changes by ±1 and counter clears.
  - The target is floorN as sampled live on each step edge; requests may change mid-travel.
  - After a step, if the new floor == floorN, go to DOOR_OPEN with door counter = 0.
  - If floorN is now on the opposite side, switch direction; the new direction applies from the next step.
  - Otherwise continue in the same direction.
  - If floorN equals the current floor between steps, the car still completes no extra step. On the next step boundary it re-evaluates: if the target equals the current floor, go straight to DOOR_OPEN without moving.
- Floor arithmetic: current floor never goes below 0 or above 7. No wrap-around; a step that would go beyond 0 or 7 is suppressed. This cannot occur with a valid 3-bit target, but the guard is required.
- DOOR_OPEN:
  - floorN is ignored.
  - Door counter increments each cycle; on DOOR_CYCLES-1 go to IDLE.
  - The pending request is evaluated in IDLE on the following cycle.
- Latency: with a request sampled at edge k while the car is IDLE, the first floor change appears at edge k+1+MOVE_CYCLES. Each later floor takes MOVE_CYCLES edges.
- Simultaneous events: the three cars never interact. The same request on multiple cars moves each car independently. A soft reset of one car leaves the other two untouched.

Test Plan:
- Assert rst for 1 edge; release. All outN = 000. Hold floorN = 000 for 10 cycles: outputs stay 000 and the cars stay IDLE.
- From reset, floor1 = 3, sampled at edge k:
  - out1 = 1 at k+3, 2 at k+5, 3 at k+7 (default params).
  - out1 holds 3 through the door cycles.
  - out2 and out3 remain 000.
- Set floor2 = 5 then floor3 = 7 at staggered times: each output steps by +1 every 2 cycles independently. out3 reaches 7 and stays at 7; no wrap to 0.
- Car 1 at 3, IDLE; set floor1 = 2 → out1 = 2 two cycles after entering MOVE_DOWN, then DOOR_OPEN.
- Car 3 moving up at floor 4 toward 7; change floor3 = 1 → car 3 reverses at the next step boundary and descends 1 floor per 2 cycles until out3 = 1.
- Car 2 mid-move at floor 3; pulse rst2 for 1 edge → out2 = 000 on that edge with the car IDLE. out1 and out3 continue unaffected. With floor2 still 4, car 2 restarts the climb.

Source files
------------

// File: rtl/top.sv
// Three-car elevator controller: three identical, independent per-car FSMs
// sharing one clock. Each car follows a live floor request one floor at a time.
// Each car holds its door open for a fixed time on arrival.

module elevator_car #(
  parameter int unsigned MOVE_CYCLES = 2,
  parameter int unsigned DOOR_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] floor_i,
  output logic [2:0] floor_o
);

  localparam int unsigned MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  // state_q is the observable FSM state for checkers.
  state_t        state_q;
  logic [2:0]    cur_q;
  logic [2:0]    tgt_q;
  logic [MW-1:0] step_cnt_q;
  logic [DW-1:0] door_cnt_q;
  logic [2:0]    step_floor_d;

  // Floor after one step toward the live target, clamped to 0..7.
  always_comb begin
    step_floor_d = cur_q;
    if (tgt_q > cur_q && cur_q != 3'd7) begin
      step_floor_d = cur_q + 3'd1;
    end else if (tgt_q < cur_q && cur_q != 3'd0) begin
      step_floor_d = cur_q - 3'd1;
    end
  end

  // Car FSM: request sampling, travel timing, stepping and door timing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cur_q      <= 3'd0;
      tgt_q      <= 3'd0;
      step_cnt_q <= '0;
      door_cnt_q <= '0;
    end else begin
      // The request is registered every cycle; the FSM acts on the registered copy.
      tgt_q <= floor_i;
      case (state_q)
        IDLE: begin
          if (tgt_q > cur_q) begin
            state_q    <= MOVE_UP;
            step_cnt_q <= '0;
          end else if (tgt_q < cur_q) begin
            state_q    <= MOVE_DOWN;
            step_cnt_q <= '0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (step_cnt_q != MOVE_LAST) begin
            step_cnt_q <= step_cnt_q + MW'(1);
          end else begin
            step_cnt_q <= '0;
            if (tgt_q == cur_q) begin
              // Target moved onto this floor mid-travel: open without moving.
              state_q    <= DOOR_OPEN;
              door_cnt_q <= '0;
            end else begin
              cur_q <= step_floor_d;
              if (step_floor_d == tgt_q) begin
                state_q    <= DOOR_OPEN;
                door_cnt_q <= '0;
              end else if (tgt_q > step_floor_d) begin
                state_q <= MOVE_UP;
              end else begin
                state_q <= MOVE_DOWN;
              end
            end
          end
        end
        DOOR_OPEN: begin
          if (door_cnt_q == DOOR_LAST) begin
            state_q    <= IDLE;
            door_cnt_q <= '0;
          end else begin
            door_cnt_q <= door_cnt_q + DW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign floor_o = cur_q;

endmodule

module top #(
  parameter int unsigned MOVE_CYCLES = 2,
  parameter int unsigned DOOR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst1,
  input  logic       rst2,
  input  logic       rst3,
  input  logic [2:0] floor1,
  input  logic [2:0] floor2,
  input  logic [2:0] floor3,
  output logic [2:0] out1,
  output logic [2:0] out2,
  output logic [2:0] out3
);

  elevator_car #(.MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) u_car1 (
    .clk_i(clk), .rst_i(rst | rst1), .floor_i(floor1), .floor_o(out1)
  );

  elevator_car #(.MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) u_car2 (
    .clk_i(clk), .rst_i(rst | rst2), .floor_i(floor2), .floor_o(out2)
  );

  elevator_car #(.MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) u_car3 (
    .clk_i(clk), .rst_i(rst | rst3), .floor_i(floor3), .floor_o(out3)
  );

endmodule

// File: tb/tb_top.sv
// Directed bench for the three-car elevator controller. Each check is an
// immediate assertion against a hand-computed expected value.

module tb_top;

  logic       clk;
  logic       rst, rst1, rst2, rst3;
  logic [2:0] floor1, floor2, floor3;
  logic [2:0] out1, out2, out3;

  int n_cmp;
  int n_fail;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UP   = 3'd1;
  localparam logic [2:0] S_DOWN = 3'd2;
  localparam logic [2:0] S_DOOR = 3'd3;

  top dut (
    .clk(clk), .rst(rst), .rst1(rst1), .rst2(rst2), .rst3(rst3),
    .floor1(floor1), .floor2(floor2), .floor3(floor3),
    .out1(out1), .out2(out2), .out3(out3)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    floor1 = 3'd0; floor2 = 3'd0; floor3 = 3'd0;

    // Global reset for one edge.
    tick(1);
    rst = 1'b0;
    chk("rst_out1", out1, 3'd0);
    chk("rst_out2", out2, 3'd0);
    chk("rst_out3", out3, 3'd0);

    // Requests held at floor 0: nothing moves, no door cycle.
    tick(10);
    chk("hold_out1", out1, 3'd0);
    chk("hold_out2", out2, 3'd0);
    chk("hold_out3", out3, 3'd0);
    chk("hold_st1", {1'b0, dut.u_car1.state_q}, S_IDLE);
    chk("hold_st2", {1'b0, dut.u_car2.state_q}, S_IDLE);
    chk("hold_st3", {1'b0, dut.u_car3.state_q}, S_IDLE);

    // Car 1 to floor 3; request sampled at edge k.
    floor1 = 3'd3;
    tick(1);                                   // k
    tick(2);                                   // k+2
    chk("c1_up_k2", out1, 3'd0);
    tick(1);                                   // k+3
    chk("c1_up_k3", out1, 3'd1);
    tick(2);                                   // k+5
    chk("c1_up_k5", out1, 3'd2);
    tick(2);                                   // k+7
    chk("c1_up_k7", out1, 3'd3);
    chk("c1_door_k7", {1'b0, dut.u_car1.state_q}, S_DOOR);
    tick(1);                                   // k+8
    chk("c1_hold_k8", out1, 3'd3);
    chk("c1_door_k8", {1'b0, dut.u_car1.state_q}, S_DOOR);
    tick(1);                                   // k+9
    chk("c1_idle_k9", {1'b0, dut.u_car1.state_q}, S_IDLE);
    chk("c1_hold_k9", out1, 3'd3);
    chk("c2_quiet", out2, 3'd0);
    chk("c3_quiet", out3, 3'd0);

    // Staggered requests: car 2 to 5 (sampled at j), car 3 to 7 (sampled at j+1).
    floor2 = 3'd5;
    tick(1);                                   // j
    floor3 = 3'd7;
    tick(1);                                   // j+1
    tick(2);                                   // j+3
    chk("c2_j3", out2, 3'd1);
    chk("c3_j3", out3, 3'd0);
    tick(1);                                   // j+4
    chk("c2_j4", out2, 3'd1);
    chk("c3_j4", out3, 3'd1);
    tick(1);                                   // j+5
    chk("c2_j5", out2, 3'd2);
    chk("c3_j5", out3, 3'd1);
    tick(5);                                   // j+10
    chk("c2_j10", out2, 3'd4);
    chk("c3_j10", out3, 3'd4);

    // Car 3 reverses toward floor 1 at its next step boundary.
    floor3 = 3'd1;
    tick(1);                                   // j+11
    chk("c2_j11", out2, 3'd5);
    chk("c3_j11", out3, 3'd4);
    tick(1);                                   // j+12
    chk("c3_rev_j12", out3, 3'd3);
    chk("c3_dn_j12", {1'b0, dut.u_car3.state_q}, S_DOWN);
    tick(2);                                   // j+14
    chk("c3_j14", out3, 3'd2);
    tick(2);                                   // j+16
    chk("c3_j16", out3, 3'd1);
    chk("c3_door_j16", {1'b0, dut.u_car3.state_q}, S_DOOR);

    // Car 1 at 3 goes down one floor.
    floor1 = 3'd2;
    tick(1);                                   // m
    tick(1);                                   // m+1
    chk("c1_dn_m1", {1'b0, dut.u_car1.state_q}, S_DOWN);
    chk("c1_m1", out1, 3'd3);
    tick(2);                                   // m+3
    chk("c1_m3", out1, 3'd2);
    chk("c1_door_m3", {1'b0, dut.u_car1.state_q}, S_DOOR);
    chk("c3_m3", out3, 3'd1);
    chk("c2_m3", out2, 3'd5);

    // Car 2 soft-reset to 0 then climbs to 4; car 1 heads for 6.
    floor2 = 3'd4; rst2 = 1'b1; floor1 = 3'd6;
    tick(1);                                   // p
    rst2 = 1'b0;
    chk("c2_srst_p", out2, 3'd0);
    chk("c2_srst_st", {1'b0, dut.u_car2.state_q}, S_IDLE);
    chk("c1_p", out1, 3'd2);
    tick(4);                                   // p+4
    chk("c2_p4", out2, 3'd1);
    chk("c1_p4", out1, 3'd3);
    tick(4);                                   // p+8
    chk("c2_p8", out2, 3'd3);
    chk("c1_p8", out1, 3'd5);
    rst2 = 1'b1;                               // car 2 mid-move at floor 3
    tick(1);                                   // p+9
    rst2 = 1'b0;
    chk("c2_mid_rst", out2, 3'd0);
    chk("c2_mid_rst_st", {1'b0, dut.u_car2.state_q}, S_IDLE);
    chk("c1_p9", out1, 3'd5);
    chk("c3_p9", out3, 3'd1);
    tick(1);                                   // p+10
    chk("c1_p10", out1, 3'd6);
    chk("c2_p10", out2, 3'd0);
    tick(3);                                   // p+13
    chk("c2_restart", out2, 3'd1);

    // Car 3 climbs from 1 to the top floor and stays there.
    floor3 = 3'd7;
    tick(1);                                   // q
    tick(12);                                  // q+12
    chk("c3_q12", out3, 3'd6);
    tick(1);                                   // q+13
    chk("c3_top", out3, 3'd7);
    tick(7);                                   // q+20
    chk("c3_stay_top", out3, 3'd7);
    chk("c3_top_idle", {1'b0, dut.u_car3.state_q}, S_IDLE);

    // Global reset overrides everything.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("grst_out1", out1, 3'd0);
    chk("grst_out2", out2, 3'd0);
    chk("grst_out3", out3, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
